// File: rtl/booth_mult_seq.sv
// booth_mult_seq -- sequential radix-4 Booth multiplier, signed or unsigned.
//
// One recoded Booth digit is retired per RUN cycle. The accumulator and the
// multiplier shift register form one long register that shifts right
// arithmetically by two each cycle. Low product bits leave the accumulator
// and enter the top of the multiplier register.
//
// Ports:
//   clk          clock, all state changes on its rising edge
//   rst_n        synchronous active-low reset
//   start        begin a multiply (sampled while ready=1)
//   abort        cancel an operation in progress
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   op_a         multiplier operand
//   op_b         multiplicand operand
//   ready        a start is accepted this cycle
//   busy         operation in progress
//   done         one-cycle pulse, result outputs valid
//   prod_hi      upper half of the 2*WIDTH product
//   prod_lo      lower half of the 2*WIDTH product
//   ovf          product does not fit in WIDTH bits of the selected type
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | retiring one Booth digit per cycle
// S_DONE | result just written, done pulse high
module booth_mult_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic             ovf
);

   localparam int AW = WIDTH + 3;   // accumulator width
   localparam int MW = WIDTH + 2;   // extended multiplier width
   localparam int CW = $clog2(WIDTH/2 + 2);
   localparam logic [CW-1:0] LAST_S = CW'(WIDTH/2 - 1);
   localparam logic [CW-1:0] LAST_U = CW'(WIDTH/2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   mcand;
   logic [MW-1:0]   mq;
   logic            qm1;
   logic            sgn;
   logic [CW-1:0]   cnt;

   logic [AW-1:0]      pp;
   logic [AW-1:0]      acc_sum;
   logic [AW-1:0]      acc_nxt;
   logic [MW-1:0]      mq_nxt;
   logic [2*WIDTH-1:0] prod_nxt;
   logic               ovf_nxt;
   logic [CW-1:0]      cnt_last;

   always_comb begin
      pp = '0;
      case ({mq[1:0], qm1})
         3'b001, 3'b010: pp = mcand;
         3'b011:         pp = {mcand[AW-2:0], 1'b0};
         3'b100:         pp = -{mcand[AW-2:0], 1'b0};
         3'b101, 3'b110: pp = -mcand;
         default:        pp = '0;
      endcase
      acc_sum = acc + pp;
      acc_nxt = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
      mq_nxt  = {acc_sum[1:0], mq[MW-1:2]};
      // Signed runs shift 2*(WIDTH/2) bits into mq, leaving two stale
      // multiplier bits at the bottom; unsigned runs fill all of mq.
      if (sgn) prod_nxt = {acc_nxt[WIDTH-1:0], mq_nxt[MW-1:2]};
      else     prod_nxt = {acc_nxt[WIDTH-3:0], mq_nxt};
      if (sgn) ovf_nxt = (prod_nxt[2*WIDTH-1:WIDTH] != {WIDTH{prod_nxt[WIDTH-1]}});
      else     ovf_nxt = (prod_nxt[2*WIDTH-1:WIDTH] != '0);
      cnt_last = sgn ? LAST_S : LAST_U;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mq      <= '0;
         qm1     <= 1'b0;
         sgn     <= 1'b0;
         prod_hi <= '0;
         prod_lo <= '0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  sgn   <= signed_mode;
                  mq    <= signed_mode ? {{2{op_a[WIDTH-1]}}, op_a} : {2'b00, op_a};
                  mcand <= signed_mode ? {{3{op_b[WIDTH-1]}}, op_b} : {3'b000, op_b};
                  acc   <= '0;
                  qm1   <= 1'b0;
                  cnt   <= '0;
                  state <= S_RUN;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state <= S_IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  acc <= acc_nxt;
                  mq  <= mq_nxt;
                  qm1 <= mq[1];
                  cnt <= cnt + 1'b1;
                  if (cnt == cnt_last) begin
                     state   <= S_DONE;
                     ready   <= 1'b1;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     prod_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                     prod_lo <= prod_nxt[WIDTH-1:0];
                     ovf     <= ovf_nxt;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; it SHALL be even and at least 4.
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  request to begin a multiply; sampled only while ready=1.
REQ-005 abort  in  1  cancels an operation in progress.
REQ-006 signed_mode  in  1  selects operand type: 1 = two's-complement, 0 = unsigned; sampled with start.
REQ-007 op_a  in  WIDTH  multiplier operand.
REQ-008 op_b  in  WIDTH  multiplicand operand.
REQ-009 ready  out  1  the block can accept start this cycle.
REQ-010 busy  out  1  an operation is in progress.
REQ-011 done  out  1  one-cycle pulse; the result outputs are valid.
REQ-012 prod_hi  out  WIDTH  upper half of the 2*WIDTH product.
REQ-013 prod_lo  out  WIDTH  lower half of the 2*WIDTH product.
REQ-014 ovf  out  1  the product does not fit in WIDTH bits of the selected type.

Function
REQ-015 The block SHALL use an FSM with three states, IDLE, RUN and DONE, and SHALL contain no other states.
REQ-016 ready SHALL be 1 in IDLE and in DONE; busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur when start=1 and ready=1 at a rising edge. On accept the block SHALL latch op_a, op_b and signed_mode, clear the accumulator and iteration counter, and go to RUN.
REQ-018 The algorithm SHALL be radix-4 Booth, with one recoded digit {-2,-1,0,+1,+2}×multiplicand per RUN cycle, taken from bits [2i+1:2i-1] of the multiplier; bit -1 SHALL be 0.
REQ-019 In signed mode the operands SHALL be sign-extended. In unsigned mode the operands SHALL be zero-extended by 2 bits, so that no unsigned value is misread as negative.
REQ-020 The RUN iteration count N SHALL be WIDTH/2 in signed mode and WIDTH/2+1 in unsigned mode.
REQ-021 The accumulator SHALL be WIDTH+3 bits wide, so that ±2×multiplicand never overflows internally; each shift SHALL be arithmetic by 2.
REQ-022 After the Nth RUN cycle the FSM SHALL go to DONE; done SHALL be high for exactly one cycle, the (N+1)th cycle after the accept edge.
REQ-023 In DONE, {prod_hi, prod_lo} SHALL equal the exact product op_a×op_b, interpreted per the latched signed_mode and taken modulo 2^(2*WIDTH).
REQ-024 ovf SHALL be computed from the final product.
- Signed mode: ovf=1 iff prod_hi is not all copies of prod_lo[WIDTH-1].
- Unsigned mode: ovf=1 iff prod_hi≠0.
REQ-025 prod_hi, prod_lo and ovf SHALL hold their last DONE values until the next DONE. They SHALL NOT change during RUN or IDLE.
REQ-026 From DONE, start=1 SHALL accept a new operation (DONE→RUN) with no idle bubble; start=0 SHALL return the FSM to IDLE.
REQ-027 start while in RUN SHALL be ignored; the operands SHALL NOT be relatched.
REQ-028 abort=1 in RUN SHALL force IDLE at the next edge. No done pulse SHALL follow, and the result outputs SHALL keep their previous values.
REQ-029 abort SHALL have no effect in IDLE or DONE. If abort and start are both 1 in DONE, start SHALL win.
REQ-030 Changes to op_a, op_b or signed_mode after the accept edge SHALL NOT affect the result.

Reset
REQ-031 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE and the iteration counter, accumulator, prod_hi, prod_lo and ovf SHALL clear to 0.
REQ-032 Reset outputs SHALL be ready=1, busy=0, done=0.
REQ-033 Reset SHALL take priority over start and abort. Reset during RUN SHALL discard the operation with no done pulse.
REQ-034 Before the first clock edge with rst_n=0, output values SHALL be don't-care.

Verification (WIDTH=16)
REQ-035 Signed 3×5 → done high 9 cycles after the accept edge; prod_hi=0x0000, prod_lo=0x000F, ovf=0.
REQ-036 Signed 0x8000×0x8000 → {prod_hi,prod_lo}=0x40000000, ovf=1; signed 0xFFFF×0x0002 → 0xFFFFFFFE, ovf=0.
REQ-037 Unsigned 0xFFFF×0xFFFF → done 10 cycles after the accept edge; product 0xFFFE0001, ovf=1.
REQ-038 Back-to-back: start held high through DONE with a new operation 7×(-2) signed → second done 9 cycles after the first; product 0xFFFFFFF2.
REQ-039 abort in the 4th RUN cycle → IDLE next cycle; no done; the previous product is held. Reset in the 4th RUN cycle → all outputs at reset values next cycle.
REQ-040 A random signed/unsigned regression of at least 10k vectors, including 0, ±1, min and max values, SHALL match a reference model exactly.
